// File: rtl/rgb666to111.sv
// RGB666 to RGB111 quantiser with 4x4 ordered (Bayer) dither or a fixed threshold.
// Two-stage pipeline; valid and syncs are delayed to stay aligned with the pixel data.
module rgb666to111 #(
  parameter int THRESHOLD = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dither_en,
  input  logic       pixel_valid_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [5:0] red_in,
  input  logic [5:0] green_in,
  input  logic [5:0] blue_in,
  output logic       pixel_valid_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       red_out,
  output logic       green_out,
  output logic       blue_out
);

  localparam logic [5:0] FIXED_THR = 6'(THRESHOLD);

  logic       hsync_d, vsync_d;
  logic [1:0] x_cnt, y_cnt;
  logic       h_rise, v_rise;
  logic [1:0] x_eff, y_eff;
  logic [3:0] bayer;
  logic [5:0] thr_next;

  logic       s1_valid, s1_hsync, s1_vsync;
  logic [5:0] s1_red, s1_green, s1_blue, s1_thr;

  function automatic logic [3:0] bayer_lut(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] b;
    case ({y, x})
      4'b00_00: b = 4'd0;
      4'b00_01: b = 4'd8;
      4'b00_10: b = 4'd2;
      4'b00_11: b = 4'd10;
      4'b01_00: b = 4'd12;
      4'b01_01: b = 4'd4;
      4'b01_10: b = 4'd14;
      4'b01_11: b = 4'd6;
      4'b10_00: b = 4'd3;
      4'b10_01: b = 4'd11;
      4'b10_10: b = 4'd1;
      4'b10_11: b = 4'd9;
      4'b11_00: b = 4'd15;
      4'b11_01: b = 4'd7;
      4'b11_10: b = 4'd13;
      default:  b = 4'd5;
    endcase
    return b;
  endfunction

  always_comb begin
    h_rise   = hsync_in & ~hsync_d;
    v_rise   = vsync_in & ~vsync_d;
    x_eff    = (h_rise | v_rise) ? '0 : x_cnt;
    y_eff    = v_rise ? '0 : (h_rise ? y_cnt + 2'd1 : y_cnt);
    bayer    = bayer_lut(y_eff, x_eff);
    // T = 4*B + 2, always within 2..62
    thr_next = dither_en ? {bayer, 2'b10} : FIXED_THR;
  end

  // Counters follow the effective coordinates: y_eff/x_eff already fold in the
  // sync-edge resets, so holding is simply "load the effective value".
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_d <= 1'b0;
      vsync_d <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      hsync_d <= hsync_in;
      vsync_d <= vsync_in;
      y_cnt   <= y_eff;
      x_cnt   <= pixel_valid_in ? x_eff + 2'd1 : x_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
      s1_red   <= '0;
      s1_green <= '0;
      s1_blue  <= '0;
      s1_thr   <= '0;
    end else begin
      s1_valid <= pixel_valid_in;
      s1_hsync <= hsync_in;
      s1_vsync <= vsync_in;
      s1_red   <= red_in;
      s1_green <= green_in;
      s1_blue  <= blue_in;
      s1_thr   <= thr_next;
    end
  end

  // Blanked pixels drive 0 on all colour outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_valid_out <= 1'b0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      red_out         <= 1'b0;
      green_out       <= 1'b0;
      blue_out        <= 1'b0;
    end else begin
      pixel_valid_out <= s1_valid;
      hsync_out       <= s1_hsync;
      vsync_out       <= s1_vsync;
      red_out         <= s1_valid & (s1_red   >= s1_thr);
      green_out       <= s1_valid & (s1_green >= s1_thr);
      blue_out        <= s1_valid & (s1_blue  >= s1_thr);
    end
  end

endmodule

// File: tb/tb_rgb666to111.sv
// Bench for rgb666to111: behavioural model checked every cycle plus literal
// expectations from the directed scenarios, followed by a randomized phase.
module tb_rgb666to111;

  logic       clk = 1'b0;
  logic       reset, dither_en, pixel_valid_in, hsync_in, vsync_in;
  logic [5:0] red_in, green_in, blue_in;
  logic       pixel_valid_out, hsync_out, vsync_out, red_out, green_out, blue_out;

  rgb666to111 #(.THRESHOLD(32)) dut (
    .clk(clk), .reset(reset), .dither_en(dither_en),
    .pixel_valid_in(pixel_valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pixel_valid_out(pixel_valid_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
  );

  always #6 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Reference model: integer coordinates and the matrix straight from the table.
  int BAYER [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int m_x = 0, m_y = 0, m_xe = 0;
  bit m_hd = 0, m_vd = 0, m_hr = 0, m_vr = 0;
  bit p_v = 0, p_h = 0, p_vs = 0;
  int p_r = 0, p_g = 0, p_b = 0, p_t = 0;
  logic [5:0] exp_o = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_hd = 0; m_vd = 0; m_x = 0; m_y = 0;
      p_v = 0; p_h = 0; p_vs = 0; p_r = 0; p_g = 0; p_b = 0; p_t = 0;
      exp_o = '0;
    end else begin
      exp_o = {p_v, p_h, p_vs, p_v && (p_r >= p_t), p_v && (p_g >= p_t), p_v && (p_b >= p_t)};
      m_hr = hsync_in && !m_hd;
      m_vr = vsync_in && !m_vd;
      m_hd = hsync_in;
      m_vd = vsync_in;
      if (m_vr) begin m_y = 0; m_x = 0; end
      else if (m_hr) begin m_y = (m_y + 1) % 4; m_x = 0; end
      m_xe = m_x;
      if (pixel_valid_in) m_x = (m_x + 1) % 4;
      p_t  = dither_en ? 4 * BAYER[m_y][m_xe] + 2 : 32;
      p_v  = pixel_valid_in; p_h = hsync_in; p_vs = vsync_in;
      p_r  = int'(red_in); p_g = int'(green_in); p_b = int'(blue_in);
    end
  end

  int         lit_tgt[$];
  logic [5:0] lit_val[$];
  string      lit_name[$];

  always @(negedge clk) begin
    logic [5:0] act;
    act = {pixel_valid_out, hsync_out, vsync_out, red_out, green_out, blue_out};
    if (cyc >= 1) begin
      n_cmp++;
      if (act !== exp_o) begin
        n_fail++;
        $display("FAIL model cyc=%0d got={v,h,vs,r,g,b}=%b want=%b", cyc, act, exp_o);
      end
    end
    while (lit_tgt.size() > 0 && lit_tgt[0] <= cyc) begin
      n_cmp++;
      if (lit_tgt[0] != cyc || act !== lit_val[0]) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%b want=%b", lit_name[0], cyc, act, lit_val[0]);
      end
      void'(lit_tgt.pop_front());
      void'(lit_val.pop_front());
      void'(lit_name.pop_front());
    end
  end

  task automatic drv(input logic rst, input logic vl, input logic hs, input logic vs,
                     input logic den, input logic [5:0] r, input logic [5:0] g,
                     input logic [5:0] b);
    @(posedge clk);
    #1;
    reset = rst; pixel_valid_in = vl; hsync_in = hs; vsync_in = vs;
    dither_en = den; red_in = r; green_in = g; blue_in = b;
  endtask

  task automatic px(input logic den, input logic [5:0] c);
    drv(1'b0, 1'b1, 1'b0, 1'b0, den, c, c, c);
  endtask

  function automatic void lit(input string name, input int lat, input logic [5:0] val);
    lit_tgt.push_back(cyc + lat);
    lit_val.push_back(val);
    lit_name.push_back(name);
  endfunction

  initial begin
    reset = 1'b1; dither_en = 1'b0; pixel_valid_in = 1'b0; hsync_in = 1'b0;
    vsync_in = 1'b0; red_in = '0; green_in = '0; blue_in = '0;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd63, 6'd63, 6'd63);
    lit("reset_state", 1, 6'b000000);

    // fixed threshold 32
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd31, 6'd32, 6'd63);
    lit("fixed_thr", 2, 6'b100011);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    lit("hsync_delay", 2, 6'b010000);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
    lit("vsync_delay", 2, 6'b001000);

    // dither row 0 after the vsync rise: T = 2, 34, 10, 42, then wrap to 2
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0);
    px(1'b1, 6'd32); lit("row0_x0", 2, 6'b100111);
    px(1'b1, 6'd32); lit("row0_x1", 2, 6'b100000);
    px(1'b1, 6'd32); lit("row0_x2", 2, 6'b100111);
    px(1'b1, 6'd32); lit("row0_x3", 2, 6'b100000);
    px(1'b1, 6'd32); lit("row0_wrap", 2, 6'b100111);

    // hsync rise coincident with pixel: x=0,y=1 -> T=50, then 18, 58, 26
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd32, 6'd32, 6'd32);
    lit("row1_x0", 2, 6'b110000);
    px(1'b1, 6'd32); lit("row1_x1", 2, 6'b100111);
    px(1'b1, 6'd32); lit("row1_x2", 2, 6'b100000);
    px(1'b1, 6'd32); lit("row1_x3", 2, 6'b100111);

    // extremes across all 16 positions, blanked 63s between
    for (int ln = 0; ln < 4; ln++) begin
      drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0);
      drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0);
      for (int k = 0; k < 4; k++) begin px(1'b1, 6'd0);  lit("zero_in", 2, 6'b100000); end
      drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 6'd63, 6'd63);
      lit("blank", 2, 6'b000000);
      for (int k = 0; k < 4; k++) begin px(1'b1, 6'd63); lit("full_in", 2, 6'b100111); end
    end

    // three line pulses then simultaneous h/v rise
    for (int ln = 0; ln < 3; ln++) begin
      drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0);
      px(1'b1, 6'd32);
    end
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd0);
    lit("both_sync", 2, 6'b011000);
    px(1'b1, 6'd32); lit("after_both_sync", 2, 6'b100111);
    px(1'b1, 6'd32);

    // reset mid-line with pixels in flight
    px(1'b1, 6'd40);
    px(1'b1, 6'd40);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd40, 6'd40, 6'd40);
    lit("mid_reset", 1, 6'b000000);
    px(1'b1, 6'd32); lit("post_reset_px", 2, 6'b100111);
    px(1'b1, 6'd32); lit("post_reset_x1", 2, 6'b100000);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic rst, vl, hs, vs, den;
      logic [5:0] r, g, b;
      rst = ($urandom_range(0, 299) == 0);
      vl  = ($urandom_range(0, 3) != 0);
      hs  = ($urandom_range(0, 9) < 2) ? ~hsync_in : hsync_in;
      vs  = ($urandom_range(0, 49) == 0) ? ~vsync_in : vsync_in;
      den = ($urandom_range(0, 15) == 0) ? ~dither_en : dither_en;
      r = 6'($urandom_range(0, 63));
      g = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      b = ($urandom_range(0, 7) == 0) ? 6'd0  : 6'($urandom_range(0, 63));
      drv(rst, vl, hs, vs, den, r, g, b);
    end
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

    if (lit_tgt.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL lit_queue_drain got=%0d pending want=0", lit_tgt.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
